lcd_shared_refresh_ctrl: RTL and testbench
==========================================

Name: lcd_shared_refresh_ctrl

Overview:
Owns the LCD_Controller start/done handshake. After reset it issues the HD44780 init sequence once, then continuously refreshes a 2x16 character display from an internal 32-cell shadow buffer. Two independent requesters (e.g. game logic and status/score logic) write cells into the shadow buffer through a round-robin arbiter. It sits between the application logic and the existing LCD_Controller and replaces per-cell wide input buses.

Parameters:
DLY_CYCLES, 589824, idle cycles inserted after each oDone; must cover worst-case clear/command time; shrink in simulation.
DLY_W, 20, width of the delay counter; must satisfy 2**DLY_W > DLY_CYCLES.

Ports:
iCLK  in  1  system clock
iRST_N  in  1  reset, synchronous, active-low
iREQ  in  2  per-requester write request; held until granted
iADDR0  in  5  requester 0 cell: [4] = line (0 top, 1 bottom), [3:0] = column
iCHAR0  in  8  requester 0 character code
iADDR1  in  5  requester 1 cell
iCHAR1  in  8  requester 1 character code
oGRANT  out  2  one-hot grant, combinational; the write takes effect at the same clock edge
oLCD_DATA  out  8  to LCD_Controller iDATA
oLCD_RS  out  1  to LCD_Controller iRS (0 = command, 1 = data)
oLCD_START  out  1  to LCD_Controller iStart
iLCD_DONE  in  1  from LCD_Controller oDone
oINIT_DONE  out  1  high once the init sequence has completed
oFRAME_PULSE  out  1  one-cycle pulse at the end of each full 34-transfer refresh frame

Behaviour:
- Reset (iRST_N low at an edge):
  - oLCD_START = 0, oLCD_DATA = 0, oLCD_RS = 0, oINIT_DONE = 0, oFRAME_PULSE = 0.
  - Sequence index = 0, delay counter = 0, RR pointer = 0.
  - All 32 shadow cells = 8'h20 (space).
  - Reset mid-transfer aborts the transfer immediately. The init sequence restarts from step 0.
- Transfer FSM states: LOAD -> WAIT -> DELAY -> NEXT -> LOAD.
  - LOAD: latch data/RS for the current index into oLCD_DATA/oLCD_RS; set oLCD_START = 1.
  - WAIT: when iLCD_DONE = 1, drop oLCD_START to 0 and go to DELAY. There is no timeout.
  - DELAY: count to DLY_CYCLES-1, then clear the counter and go to NEXT.
  - NEXT: advance the index and return to LOAD.
- Init phase, indices 0..4, all RS = 0: 8'h38, 8'h0C, 8'h01, 8'h06, 8'h80. oINIT_DONE rises in the NEXT cycle after index 4 and stays high until the next reset.
- Refresh phase, frame indices 0..33, repeated forever:
  - 0..15: RS = 1, shadow[0..15].
  - 16: RS = 0, 8'hC0.
  - 17..32: RS = 1, shadow[16..31].
  - 33: RS = 0, 8'h80.
  - After index 33 the index wraps to 0, and oFRAME_PULSE fires for one cycle in that NEXT state.
- Shadow read happens at LOAD time. A write that lands after LOAD for the same cell appears in the next frame. A write and a LOAD of the same cell at the same edge: LOAD takes the old value.
- Arbiter:
  - Single request: granted immediately.
  - Both requesting: grant goes to the requester the RR pointer favours (pointer 0 favours req0). After any grant the pointer points at the other requester.
  - At most one write per cycle.
  - Granted write: shadow[iADDRx] <= iCHARx at that edge.
  - Writes are accepted at all times, including during the init phase and during reset-release (the first active cycle).
  - While iRST_N is low, oGRANT = 0.
- No backpressure to requesters beyond grant. Worst-case wait is 1 cycle when both requesters hold their requests.

Decomposition:
- Shared package lcd_pkg holds:
  - command constants: FUNC_SET 8'h38, DISP_ON 8'h0C, CLR 8'h01, ENTRY 8'h06, LINE1_ADDR 8'h80, LINE2_ADDR 8'hC0;
  - INIT_LEN = 5, FRAME_LEN = 34, SPACE = 8'h20;
  - the transfer-state enum.
- One sub-module: lcd_rr_arbiter, a 2-way round-robin arbiter. Inputs: req[1:0]. Outputs: grant[1:0] and the selected addr/char. It holds the pointer register internally.

Test Plan (behavioural LCD_Controller model returns oDone 3 cycles after start; DLY_CYCLES = 4):
- Release reset -> first five LOADs present RS = 0 with data 38, 0C, 01, 06, 80 in order; oINIT_DONE rises after the fifth; no LOAD occurs while oLCD_START is high awaiting done.
- No writes -> first frame sends 16x 8'h20 (RS = 1), C0 (RS = 0), 16x 8'h20, 80; oFRAME_PULSE is exactly one cycle after transfer 33.
- Requester 0 writes addr 5'h00 = 8'h48 and requester 1 writes addr 5'h1F = 8'h21 on different cycles -> next frame shows 48 as transfer 0 and 21 as transfer 32.
- Both requesters hold requests simultaneously for 4 cycles with distinct addresses -> grants alternate 01, 10, 01, 10 (pointer starts at 0); each grant is one-hot and a write occurs each cycle.
- Write to cell 3 at the same edge as the LOAD of cell 3 -> old char is sent this frame and the new char in the following frame.
- Assert reset during WAIT of frame index 20 -> oLCD_START is 0 at the next edge; after release the bench sees 38 again and all cells read back as 8'h20.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants and types for the LCD refresh controller.
// Contents: HD44780 command bytes, sequence lengths, the blank character,
// the transfer-state enum and the init-command lookup.
package lcd_pkg;

   localparam logic [7:0] FUNC_SET   = 8'h38;
   localparam logic [7:0] DISP_ON    = 8'h0C;
   localparam logic [7:0] CLR        = 8'h01;
   localparam logic [7:0] ENTRY      = 8'h06;
   localparam logic [7:0] LINE1_ADDR = 8'h80;
   localparam logic [7:0] LINE2_ADDR = 8'hC0;

   localparam int INIT_LEN  = 5;
   localparam int FRAME_LEN = 34;

   localparam logic [7:0] SPACE = 8'h20;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DELAY = 2'd2,
      ST_NEXT  = 2'd3
   } xfer_state_e;

   function automatic logic [7:0] init_cmd(input logic [2:0] idx);
      logic [7:0] cmd;
      case (idx)
         3'd0:    cmd = FUNC_SET;
         3'd1:    cmd = DISP_ON;
         3'd2:    cmd = CLR;
         3'd3:    cmd = ENTRY;
         default: cmd = LINE1_ADDR;
      endcase
      return cmd;
   endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Two-way round-robin arbiter for shadow-buffer writes.
// Ports:
//   clk_i, rst_ni         clock, synchronous active-low reset
//   req_i[1:0]            per-requester request
//   addr0_i/char0_i       requester 0 cell and character
//   addr1_i/char1_i       requester 1 cell and character
//   grant_o[1:0]          one-hot grant (combinational), zero while in reset
//   addr_o/char_o         cell and character of the granted requester
module lcd_rr_arbiter (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] req_i,
   input  logic [4:0] addr0_i,
   input  logic [7:0] char0_i,
   input  logic [4:0] addr1_i,
   input  logic [7:0] char1_i,
   output logic [1:0] grant_o,
   output logic [4:0] addr_o,
   output logic [7:0] char_o
);

   // ptr_q = 0 favours requester 0 on a tie
   logic ptr_q, ptr_d;

   always_comb begin
      grant_o = 2'b00;
      if (rst_ni) begin
         case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
            default: grant_o = 2'b00;
         endcase
      end
   end

   assign addr_o = grant_o[1] ? addr1_i : addr0_i;
   assign char_o = grant_o[1] ? char1_i : char0_i;

   // After any grant, favour the other requester next time
   always_comb begin
      ptr_d = ptr_q;
      if (grant_o[0])
         ptr_d = 1'b1;
      else if (grant_o[1])
         ptr_d = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni)
         ptr_q <= 1'b0;
      else
         ptr_q <= ptr_d;
   end

endmodule

// File: rtl/lcd_shared_refresh_ctrl.sv
// Drives the LCD_Controller start/done handshake: one HD44780 init sequence
// after reset, then endless refresh of a 2x16 display from a 32-cell shadow
// buffer written by two requesters through a round-robin arbiter.
// Ports:
//   iCLK, iRST_N                       clock, synchronous active-low reset
//   iREQ, iADDR0/iCHAR0, iADDR1/iCHAR1 requester write ports
//   oGRANT                             one-hot write grant
//   oLCD_DATA, oLCD_RS, oLCD_START     to LCD_Controller
//   iLCD_DONE                          from LCD_Controller
//   oINIT_DONE                         init sequence finished
//   oFRAME_PULSE                       one cycle at the end of each frame
//
// state    | meaning
// ST_LOAD  | latch data/RS for current index, raise start
// ST_WAIT  | hold start until the controller reports done
// ST_DELAY | idle DLY_CYCLES cycles for the display to settle
// ST_NEXT  | advance index (init -> frame, frame wrap)
module lcd_shared_refresh_ctrl #(
   parameter int DLY_CYCLES = 589824,
   parameter int DLY_W      = 20
) (
   input  logic       iCLK,
   input  logic       iRST_N,
   input  logic [1:0] iREQ,
   input  logic [4:0] iADDR0,
   input  logic [7:0] iCHAR0,
   input  logic [4:0] iADDR1,
   input  logic [7:0] iCHAR1,
   output logic [1:0] oGRANT,
   output logic [7:0] oLCD_DATA,
   output logic       oLCD_RS,
   output logic       oLCD_START,
   input  logic       iLCD_DONE,
   output logic       oINIT_DONE,
   output logic       oFRAME_PULSE
);
   import lcd_pkg::*;

   localparam logic [DLY_W-1:0] DLY_LAST   = DLY_W'(DLY_CYCLES - 1);
   localparam logic [5:0]       INIT_LAST  = 6'(INIT_LEN - 1);
   localparam logic [5:0]       FRAME_LAST = 6'(FRAME_LEN - 1);

   xfer_state_e      state_q, state_d;
   logic [5:0]       idx_q, idx_d;
   logic [DLY_W-1:0] dly_q, dly_d;
   logic [7:0]       data_q, data_d;
   logic             rs_q, rs_d;
   logic             start_q, start_d;
   logic             init_done_q, init_done_d;
   logic             frame_pulse;

   logic [7:0]       shadow_q [32];
   logic [4:0]       wr_addr;
   logic [7:0]       wr_char;
   logic [7:0]       ld_data;
   logic             ld_rs;
   logic [4:0]       cell_idx;

   lcd_rr_arbiter u_arb (
      .clk_i   (iCLK),
      .rst_ni  (iRST_N),
      .req_i   (iREQ),
      .addr0_i (iADDR0),
      .char0_i (iCHAR0),
      .addr1_i (iADDR1),
      .char1_i (iCHAR1),
      .grant_o (oGRANT),
      .addr_o  (wr_addr),
      .char_o  (wr_char)
   );

   // A LOAD at the same edge as a write reads the pre-write value
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         for (int i = 0; i < 32; i++)
            shadow_q[i] <= SPACE;
      end else if (|oGRANT) begin
         shadow_q[wr_addr] <= wr_char;
      end
   end

   // Frame indices 17..32 map to cells 16..31; the 5-bit subtract wraps 32 to 31
   assign cell_idx = idx_q[4:0] - 5'd1;

   always_comb begin
      ld_data = SPACE;
      ld_rs   = 1'b0;
      if (!init_done_q) begin
         ld_data = init_cmd(idx_q[2:0]);
      end else if (idx_q < 6'd16) begin
         ld_rs   = 1'b1;
         ld_data = shadow_q[idx_q[4:0]];
      end else if (idx_q == 6'd16) begin
         ld_data = LINE2_ADDR;
      end else if (idx_q < FRAME_LAST) begin
         ld_rs   = 1'b1;
         ld_data = shadow_q[cell_idx];
      end else begin
         ld_data = LINE1_ADDR;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      dly_d       = dly_q;
      data_d      = data_q;
      rs_d        = rs_q;
      start_d     = start_q;
      init_done_d = init_done_q;
      frame_pulse = 1'b0;
      case (state_q)
         ST_LOAD: begin
            data_d  = ld_data;
            rs_d    = ld_rs;
            start_d = 1'b1;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (iLCD_DONE) begin
               start_d = 1'b0;
               state_d = ST_DELAY;
            end
         end
         ST_DELAY: begin
            if (dly_q == DLY_LAST) begin
               dly_d   = '0;
               state_d = ST_NEXT;
            end else begin
               dly_d = dly_q + DLY_W'(1);
            end
         end
         ST_NEXT: begin
            state_d = ST_LOAD;
            if (!init_done_q) begin
               if (idx_q == INIT_LAST) begin
                  idx_d       = '0;
                  init_done_d = 1'b1;
               end else begin
                  idx_d = idx_q + 6'd1;
               end
            end else if (idx_q == FRAME_LAST) begin
               idx_d       = '0;
               frame_pulse = 1'b1;
            end else begin
               idx_d = idx_q + 6'd1;
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         state_q     <= ST_LOAD;
         idx_q       <= '0;
         dly_q       <= '0;
         data_q      <= '0;
         rs_q        <= 1'b0;
         start_q     <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         dly_q       <= dly_d;
         data_q      <= data_d;
         rs_q        <= rs_d;
         start_q     <= start_d;
         init_done_q <= init_done_d;
      end
   end

   assign oLCD_DATA    = data_q;
   assign oLCD_RS      = rs_q;
   assign oLCD_START   = start_q;
   assign oINIT_DONE   = init_done_q;
   assign oFRAME_PULSE = frame_pulse;

endmodule

// File: tb/tb_lcd_shared_refresh_ctrl.sv
// Self-checking bench for lcd_shared_refresh_ctrl with a 3-cycle LCD
// controller responder and a scoreboard of the shadow buffer and transfers.
module tb_lcd_shared_refresh_ctrl;

   localparam int DLY = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] req = 2'b00;
   logic [4:0] addr0 = '0, addr1 = '0;
   logic [7:0] ch0 = '0, ch1 = '0;
   logic [1:0] grant;
   logic [7:0] lcd_data;
   logic       lcd_rs, lcd_start;
   logic       lcd_done = 1'b0;
   logic       init_done, frame_pulse;

   int checks = 0;
   int errors = 0;

   lcd_shared_refresh_ctrl #(.DLY_CYCLES(DLY), .DLY_W(3)) dut (
      .iCLK(clk), .iRST_N(rst_n), .iREQ(req),
      .iADDR0(addr0), .iCHAR0(ch0), .iADDR1(addr1), .iCHAR1(ch1),
      .oGRANT(grant), .oLCD_DATA(lcd_data), .oLCD_RS(lcd_rs),
      .oLCD_START(lcd_start), .iLCD_DONE(lcd_done),
      .oINIT_DONE(init_done), .oFRAME_PULSE(frame_pulse)
   );

   always #5 clk = ~clk;

   // LCD_Controller responder: done is seen by the DUT 3 edges after start rises
   int lcd_cnt = 0;
   always @(negedge clk) begin
      if (lcd_start !== 1'b1) begin
         lcd_cnt  = 0;
         lcd_done = 1'b0;
      end else if (!lcd_done) begin
         lcd_cnt++;
         if (lcd_cnt == 3) lcd_done = 1'b1;
      end
   end

   // ---------------- reference model ----------------
   logic [7:0] m_shadow [32];
   bit         m_ptr = 1'b0;
   bit         pend_rst = 1'b1;
   bit         pend_we = 1'b0;
   logic [4:0] pend_addr;
   logic [7:0] pend_char;
   bit         m_refresh = 1'b0;
   int         m_idx = 0;
   int         pulse_seen = 0;
   bit         pulse_due = 1'b0;
   logic       prev_start = 1'b0;
   logic [8:0] prev_xfer = '0;
   logic [8:0] cur_frame [34];
   logic [8:0] frame_log [34];
   int         frames_done = 0;
   int         xfers = 0;
   int         pulses_total = 0;

   function automatic logic [8:0] exp_xfer(input bit refr, input int idx);
      if (!refr) begin
         case (idx)
            0: return {1'b0, 8'h38};
            1: return {1'b0, 8'h0C};
            2: return {1'b0, 8'h01};
            3: return {1'b0, 8'h06};
            default: return {1'b0, 8'h80};
         endcase
      end
      if (idx < 16)  return {1'b1, m_shadow[idx]};
      if (idx == 16) return {1'b0, 8'hC0};
      if (idx < 33)  return {1'b1, m_shadow[idx-1]};
      return {1'b0, 8'h80};
   endfunction

   // Runs mid low-phase; shadow updates are committed one edge late so that a
   // transfer latched at edge N is compared against writes from edges < N.
   always begin
      logic [8:0] ev;
      logic [1:0] eg;
      int fav, g;
      @(negedge clk); #2;
      if (frame_pulse === 1'b1) begin
         pulse_seen++;
         pulses_total++;
      end
      if (lcd_start === 1'b1 && prev_start !== 1'b1) begin
         ev = exp_xfer(m_refresh, m_idx);
         checks++;
         if ({lcd_rs, lcd_data} !== ev) begin
            errors++;
            $display("FAIL xfer refresh=%0d idx=%0d got=%h exp=%h", m_refresh, m_idx, {lcd_rs, lcd_data}, ev);
         end
         checks++;
         if (init_done !== m_refresh) begin
            errors++;
            $display("FAIL init_done at idx=%0d got=%b exp=%b", m_idx, init_done, m_refresh);
         end
         checks++;
         if (pulse_seen != int'(pulse_due)) begin
            errors++;
            $display("FAIL frame_pulse cycles got=%0d exp=%0d", pulse_seen, pulse_due);
         end
         pulse_seen = 0;
         pulse_due  = 1'b0;
         xfers++;
         if (m_refresh) cur_frame[m_idx] = {lcd_rs, lcd_data};
         if (!m_refresh && m_idx == 4) begin
            m_refresh = 1'b1;
            m_idx = 0;
         end else if (m_refresh && m_idx == 33) begin
            frame_log = cur_frame;
            frames_done++;
            pulse_due = 1'b1;
            m_idx = 0;
         end else begin
            m_idx++;
         end
      end else if (lcd_start === 1'b1) begin
         checks++;
         if ({lcd_rs, lcd_data} !== prev_xfer) begin
            errors++;
            $display("FAIL hold_while_start got=%h exp=%h", {lcd_rs, lcd_data}, prev_xfer);
         end
      end
      prev_start = lcd_start;
      prev_xfer  = {lcd_rs, lcd_data};

      if (pend_rst) begin
         for (int i = 0; i < 32; i++) m_shadow[i] = 8'h20;
         m_refresh  = 1'b0;
         m_idx      = 0;
         pulse_seen = 0;
         pulse_due  = 1'b0;
         xfers      = 0;
         checks++;
         if ({lcd_start, init_done, frame_pulse, lcd_rs, lcd_data} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=000", {lcd_start, init_done, frame_pulse, lcd_rs, lcd_data});
         end
      end else if (pend_we) begin
         m_shadow[pend_addr] = pend_char;
      end

      eg = 2'b00;
      pend_we = 1'b0;
      if (!rst_n) begin
         pend_rst = 1'b1;
         m_ptr = 1'b0;
      end else begin
         pend_rst = 1'b0;
         fav = int'(m_ptr);
         g = -1;
         if (req[fav]) g = fav;
         else if (req[1-fav]) g = 1 - fav;
         if (g >= 0) begin
            eg = 2'(1 << g);
            pend_we = 1'b1;
            pend_addr = (g == 1) ? addr1 : addr0;
            pend_char = (g == 1) ? ch1 : ch0;
            m_ptr = (g == 0);
         end
      end
      checks++;
      if (grant !== eg) begin
         errors++;
         $display("FAIL grant req=%b got=%b exp=%b", req, grant, eg);
      end
   end

   // ---------------- helpers ----------------
   task automatic wait_frames(input int n);
      int target, cyc;
      target = frames_done + n;
      cyc = 0;
      while (frames_done < target && cyc < 1500 * n) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (frames_done < target) begin
         errors++;
         $display("FAIL frame_timeout got=%0d exp=%0d", frames_done, target);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      req   = 2'($urandom_range(3, 1));
      addr0 = 5'($urandom); addr1 = 5'($urandom);
      ch0   = 8'($urandom); ch1   = 8'($urandom);
      repeat (4) @(negedge clk);
      checks++;
      if (grant !== 2'b00) begin
         errors++; $display("FAIL reset_grant got=%b exp=00", grant);
      end
      checks++;
      if ({lcd_start, lcd_rs, lcd_data, init_done, frame_pulse} !== 12'h000) begin
         errors++; $display("FAIL reset_state got=%h exp=000", {lcd_start, lcd_rs, lcd_data, init_done, frame_pulse});
      end
      // write during the first active cycle must land
      rst_n = 1'b1;
      req   = 2'b01; addr0 = 5'd7; ch0 = 8'h5A;
      #1;
      checks++;
      if (grant !== 2'b01) begin
         errors++; $display("FAIL release_grant got=%b exp=01", grant);
      end
      @(negedge clk);
      req = 2'b00;
   endtask

   task automatic test_init();
      int cyc = 0;
      while (init_done !== 1'b1 && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (init_done !== 1'b1 || xfers != 5) begin
         errors++; $display("FAIL init_seq init_done=%b xfers=%0d exp xfers=5", init_done, xfers);
      end
   endtask

   task automatic test_blank_frame();
      logic [8:0] e;
      wait_frames(1);
      for (int i = 0; i < 34; i++) begin
         if (i == 16)      e = 9'h0C0;
         else if (i == 33) e = 9'h080;
         else if (i == 7)  e = 9'h15A;
         else              e = 9'h120;
         checks++;
         if (frame_log[i] !== e) begin
            errors++; $display("FAIL blank_frame idx=%0d got=%h exp=%h", i, frame_log[i], e);
         end
      end
      checks++;
      if (pulses_total < 0 || pulses_total > 1) begin
         errors++; $display("FAIL first_pulse_count got=%0d exp<=1", pulses_total);
      end
   endtask

   task automatic test_writes();
      @(negedge clk);
      req = 2'b01; addr0 = 5'h00; ch0 = 8'h48;
      #1;
      checks++;
      if (grant !== 2'b01) begin
         errors++; $display("FAIL write0_grant got=%b exp=01", grant);
      end
      @(negedge clk);
      req = 2'b00;
      @(negedge clk);
      req = 2'b10; addr1 = 5'h1F; ch1 = 8'h21;
      #1;
      checks++;
      if (grant !== 2'b10) begin
         errors++; $display("FAIL write1_grant got=%b exp=10", grant);
      end
      @(negedge clk);
      req = 2'b00;
      wait_frames(2);
      checks++;
      if (frame_log[0] !== 9'h148) begin
         errors++; $display("FAIL cell0 got=%h exp=148", frame_log[0]);
      end
      checks++;
      if (frame_log[32] !== 9'h121) begin
         errors++; $display("FAIL cell31 got=%h exp=121", frame_log[32]);
      end
   endtask

   task automatic test_both();
      logic [1:0] eg;
      for (int i = 0; i < 4; i++) begin
         int a;
         a = $urandom_range(31, 0);
         addr0 = 5'(a);
         addr1 = 5'(a + $urandom_range(31, 1));
         ch0 = 8'($urandom_range(126, 33));
         ch1 = 8'($urandom_range(126, 33));
         req = 2'b11;
         #1;
         eg = (i % 2 == 0) ? 2'b01 : 2'b10;
         checks++;
         if (grant !== eg) begin
            errors++; $display("FAIL both_grant cycle=%0d got=%b exp=%b", i, grant, eg);
         end
         @(negedge clk);
      end
      req = 2'b00;
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         req   = 2'($urandom);
         addr0 = 5'($urandom); addr1 = 5'($urandom);
         ch0   = 8'($urandom); ch1   = 8'($urandom);
         #1;
         checks++;
         if ((grant & ~req) != 2'b00 || grant == 2'b11 || (req != 2'b00 && grant == 2'b00)) begin
            errors++; $display("FAIL rand_grant req=%b got=%b", req, grant);
         end
         @(negedge clk);
      end
      req = 2'b00;
      wait_frames(2);
      for (int c = 0; c < 32; c++) begin
         int p;
         p = (c < 16) ? c : c + 1;
         checks++;
         if (frame_log[p] !== {1'b1, m_shadow[c]}) begin
            errors++; $display("FAIL rand_cell c=%0d got=%h exp=%h", c, frame_log[p], {1'b1, m_shadow[c]});
         end
      end
   endtask

   task automatic test_same_edge();
      logic [7:0] old_c, new_c;
      int cyc = 0;
      int f0;
      old_c = m_shadow[3];
      new_c = (old_c == 8'h41) ? 8'h42 : 8'h41;
      while (!(m_refresh && m_idx == 3 && lcd_start === 1'b1) && cyc < 2000) begin
         @(negedge clk); cyc++;
      end
      while (lcd_start === 1'b1 && cyc < 2000) begin
         @(negedge clk); cyc++;
      end
      checks++;
      if (cyc >= 2000) begin
         errors++; $display("FAIL same_edge_sync timeout cycles=%0d", cyc);
      end
      // start fell at edge E; LOAD of cell 3 is at E+6 (4 DELAY, 1 NEXT, 1 LOAD)
      repeat (5) @(negedge clk);
      f0 = frames_done;
      req = 2'b01; addr0 = 5'd3; ch0 = new_c;
      @(negedge clk);
      req = 2'b00;
      wait_frames(f0 + 1 - frames_done);
      checks++;
      if (frame_log[3] !== {1'b1, old_c}) begin
         errors++; $display("FAIL same_edge_old got=%h exp=%h", frame_log[3], {1'b1, old_c});
      end
      wait_frames(1);
      checks++;
      if (frame_log[3] !== {1'b1, new_c}) begin
         errors++; $display("FAIL same_edge_new got=%h exp=%h", frame_log[3], {1'b1, new_c});
      end
   endtask

   task automatic test_reset_mid();
      logic [8:0] e;
      int cyc = 0;
      while (!(m_refresh && m_idx == 21 && lcd_start === 1'b1) && cyc < 2000) begin
         @(negedge clk); cyc++;
      end
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (lcd_start !== 1'b0) begin
         errors++; $display("FAIL reset_mid_start got=%b exp=0", lcd_start);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_frames(1);
      for (int i = 0; i < 34; i++) begin
         if (i == 16)      e = 9'h0C0;
         else if (i == 33) e = 9'h080;
         else              e = 9'h120;
         checks++;
         if (frame_log[i] !== e) begin
            errors++; $display("FAIL post_reset_frame idx=%0d got=%h exp=%h", i, frame_log[i], e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_init();
      test_blank_frame();
      test_writes();
      test_both();
      test_random();
      test_same_edge();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
